// File: rtl/fire8_pkg.sv
// Shared constants and types for the fire8 output feature-map writer.
package fire8_pkg;

    localparam int WIDTH    = 16;
    localparam int DSP_NO   = 256;
    localparam int PIXELS   = 64;
    localparam int CH_TOTAL = 512;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/fire8_snapshot_bank.sv
// DSP_NO x WIDTH snapshot register bank: parallel load of all channels, indexed read.
module fire8_snapshot_bank #(
    parameter int WIDTH  = fire8_pkg::WIDTH,
    parameter int DSP_NO = fire8_pkg::DSP_NO
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDTH-1:0]          din [DSP_NO],
    input  logic [$clog2(DSP_NO)-1:0] rd_idx,
    output logic [WIDTH-1:0]          dout
);

    logic [WIDTH-1:0] mem [DSP_NO];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DSP_NO; i++) mem[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < DSP_NO; i++) mem[i] <= din[i];
        end
    end

    assign dout = mem[rd_idx];

endmodule

// File: rtl/fire8_ex1_ofm_writer.sv
// Double-buffered capture of expand-1x1 pixels, drained one word per cycle into the
// concatenated output feature-map memory.
//   state | meaning
//   IDLE  | not armed, samples ignored
//   ARMED | capturing samples and draining banks
//   DONE  | all pixels written, samples ignored until start
module fire8_ex1_ofm_writer #(
    parameter int WIDTH     = fire8_pkg::WIDTH,
    parameter int DSP_NO    = fire8_pkg::DSP_NO,
    parameter int PIXELS    = fire8_pkg::PIXELS,
    parameter int CH_TOTAL  = fire8_pkg::CH_TOTAL,
    parameter int CH_OFFSET = 0,
    parameter int ADDR_W    = $clog2(PIXELS * CH_TOTAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ofm_valid,
    input  logic [WIDTH-1:0]  ofm [DSP_NO],
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    import fire8_pkg::*;

    localparam int CH_W  = $clog2(DSP_NO);
    localparam int PIX_W = $clog2(PIXELS);

    state_t            state, state_n;
    logic [1:0]        count, count_n;
    logic              wr_ptr, wr_ptr_n;
    logic              rd_ptr, rd_ptr_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [PIX_W-1:0]  pix, pix_n;
    logic              overflow_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] addr_n;
    logic [WIDTH-1:0]  data_n;
    logic              xfer, last_word, cap;
    logic [WIDTH-1:0]  dout0, dout1;

    fire8_snapshot_bank #(.WIDTH(WIDTH), .DSP_NO(DSP_NO)) u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .load   (cap && !wr_ptr),
        .din    (ofm),
        .rd_idx (ch_n),
        .dout   (dout0)
    );

    fire8_snapshot_bank #(.WIDTH(WIDTH), .DSP_NO(DSP_NO)) u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .load   (cap && wr_ptr),
        .din    (ofm),
        .rd_idx (ch_n),
        .dout   (dout1)
    );

    always_comb begin
        state_n    = state;
        count_n    = count;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        ch_n       = ch;
        pix_n      = pix;
        overflow_n = overflow;
        cap        = 1'b0;
        xfer       = wr_en && wr_ready;
        last_word  = xfer && (ch == CH_W'(DSP_NO - 1));

        case (state)
            IDLE: begin
                if (start) state_n = ARMED;
            end
            ARMED: begin
                if (xfer) ch_n = last_word ? '0 : ch + 1'b1;
                if (last_word) begin
                    rd_ptr_n = ~rd_ptr;
                    pix_n    = (pix == PIX_W'(PIXELS - 1)) ? '0 : pix + 1'b1;
                end
                if (last_word && (pix == PIX_W'(PIXELS - 1))) begin
                    // layer complete: anything still buffered belongs to no pixel
                    state_n  = DONE;
                    count_n  = '0;
                    wr_ptr_n = 1'b0;
                    rd_ptr_n = 1'b0;
                end else begin
                    if (ofm_valid) begin
                        if ((count != 2'd2) || last_word) cap = 1'b1;
                        else overflow_n = 1'b1;
                    end
                    count_n = count + {1'b0, cap} - {1'b0, last_word};
                    if (cap) wr_ptr_n = ~wr_ptr;
                end
            end
            DONE: begin
                if (start) state_n = ARMED;
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n    = ARMED;
            count_n    = '0;
            wr_ptr_n   = 1'b0;
            rd_ptr_n   = 1'b0;
            ch_n       = '0;
            pix_n      = '0;
            overflow_n = 1'b0;
            cap        = 1'b0;
        end

        wr_en_n = (count_n != 2'd0);
        addr_n  = ADDR_W'(pix_n) * ADDR_W'(CH_TOTAL) + ADDR_W'(CH_OFFSET) + ADDR_W'(ch_n);
    end

    // A bank being loaded this edge is not readable yet, so forward the live input.
    always_comb begin
        data_n = rd_ptr_n ? dout1 : dout0;
        if (cap && (wr_ptr == rd_ptr_n)) data_n = ofm[ch_n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            ch       <= '0;
            pix      <= '0;
            overflow <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            count    <= count_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            ch       <= ch_n;
            pix      <= pix_n;
            overflow <= overflow_n;
            wr_en    <= wr_en_n;
            wr_addr  <= addr_n;
            wr_data  <= data_n;
        end
    end

    assign busy = (count != 2'd0);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fire8_ex1_ofm_writer.sv
// Scoreboard bench for the fire8 expand-1x1 output feature-map writer.
module tb_fire8_ex1_ofm_writer;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst, start, ofm_valid, wr_ready;
    logic [15:0] ofm [N];
    logic        wr_en, busy, done, overflow;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;

    logic        rst_1, start_1, ofm_valid_1, wr_ready_1;
    logic        wr_en_1, busy_1, done_1, overflow_1;
    logic [14:0] wr_addr_1;
    logic [15:0] wr_data_1;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_hold = 1'b0;
    logic [14:0] held_addr;
    logic [15:0] held_data;
    logic done_pending = 1'b0;

    always #5 clk = ~clk;

    fire8_ex1_ofm_writer dut (
        .clk(clk), .rst(rst), .start(start), .ofm_valid(ofm_valid), .ofm(ofm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    fire8_ex1_ofm_writer #(.CH_OFFSET(256)) dut_off (
        .clk(clk), .rst(rst_1), .start(start_1), .ofm_valid(ofm_valid_1), .ofm(ofm),
        .wr_en(wr_en_1), .wr_addr(wr_addr_1), .wr_data(wr_data_1), .wr_ready(wr_ready_1),
        .busy(busy_1), .done(done_1), .overflow(overflow_1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive one pixel on the offset-0 instance; optionally queue its expected writes
    task automatic pulse(input int dbase, input int abase, input bit expect_it);
        exp_t e;
        for (int c = 0; c < N; c++) begin
            ofm[c] = 16'(dbase + c);
            if (expect_it) begin
                e.addr = abase + c;
                e.data = (dbase + c) & 16'hFFFF;
                q.push_back(e);
            end
        end
        ofm_valid = 1'b1;
        tick(1);
        ofm_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        chk("drain_queue_left", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (done_pending) begin
            chk("done_after_last", done, 1);
            done_pending = 1'b0;
        end
        if (prev_hold) begin
            chk("hold_en", wr_en, 1);
            chk("hold_addr", wr_addr, held_addr);
            chk("hold_data", wr_data, held_data);
        end
        if (wr_en && wr_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", wr_addr, wr_data);
            end else begin
                m_e = q.pop_front();
                chk("wr_addr", wr_addr, m_e.addr);
                chk("wr_data", wr_data, m_e.data);
                if (m_e.addr == 32511) begin
                    chk("done_before_last", done, 0);
                    done_pending = 1'b1;
                end
            end
        end
        prev_hold = wr_en && !wr_ready;
        held_addr = wr_addr;
        held_data = wr_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ofm_valid = 1'b0; wr_ready = 1'b1;
        rst_1 = 1'b1; start_1 = 1'b0; ofm_valid_1 = 1'b0; wr_ready_1 = 1'b1;
        for (int c = 0; c < N; c++) ofm[c] = '0;

        // reset and unarmed samples
        tick(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0; rst_1 = 1'b0;
        tick(1);
        pulse(100, 0, 0);
        tick(2);
        pulse(200, 0, 0);
        tick(3);
        chk("idle_wr_en", wr_en, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_overflow", overflow, 0);

        // single pixel, data i+1 at addr i, 256-cycle drain
        start = 1'b1; tick(1); start = 1'b0;
        pulse(1, 0, 1);
        chk("first_word_latency", wr_en, 1);
        tick(255);
        chk("busy_during_drain", busy, 1);
        tick(1);
        chk("busy_after_drain", busy, 0);
        chk("pix0_queue_left", q.size(), 0);
        chk("pix0_done", done, 0);

        // pixel 1 with alternating backpressure
        pulse(256, 512, 1);
        begin
            int k = 0;
            while (q.size() != 0 && k < 1000) begin
                wr_ready = ~wr_ready;
                tick(1);
                k++;
            end
        end
        wr_ready = 1'b1;
        chk("bp_queue_left", q.size(), 0);
        tick(2);

        // two banks fill, third sample overflows
        wr_ready = 1'b0;
        pulse(512, 1024, 1);
        tick(9);
        pulse(768, 1536, 1);
        tick(9);
        chk("ovf_before_third", overflow, 0);
        chk("busy_two_banks", busy, 1);
        pulse(1024, 0, 0);
        tick(1);
        chk("ovf_after_third", overflow, 1);
        tick(5);
        chk("ovf_sticky_stalled", overflow, 1);
        wr_ready = 1'b1;
        wait_drain(700);
        chk("ovf_sticky_drained", overflow, 1);
        tick(5);
        chk("ovf_no_extra_write", wr_en, 0);
        chk("ovf_busy_end", busy, 0);

        // full layer of 64 pixels
        start = 1'b1; tick(1); start = 1'b0;
        chk("start_clears_ovf", overflow, 0);
        chk("start_done_low", done, 0);
        for (int p = 0; p < 64; p++) begin
            pulse(p * 256, p * 512, 1);
            tick(259);
        end
        chk("layer_queue_left", q.size(), 0);
        chk("layer_done", done, 1);
        pulse(7, 0, 0);
        tick(5);
        chk("done_ignores_wr_en", wr_en, 0);
        chk("done_ignores_busy", busy, 0);
        chk("done_ignores_ovf", overflow, 0);
        chk("done_level", done, 1);

        // CH_OFFSET=256 instance with mid-drain reset
        start_1 = 1'b1; tick(1); start_1 = 1'b0;
        for (int c = 0; c < N; c++) ofm[c] = 16'(3000 + c);
        ofm_valid_1 = 1'b1; tick(1); ofm_valid_1 = 1'b0;
        chk("off_first_en", wr_en_1, 1);
        chk("off_first_addr", wr_addr_1, 256);
        chk("off_first_data", wr_data_1, 3000);
        tick(100);
        chk("off_word100_en", wr_en_1, 1);
        chk("off_word100_addr", wr_addr_1, 356);
        chk("off_word100_data", wr_data_1, 3100);
        #2 rst_1 = 1'b1;
        #1;
        chk("off_rst_wr_en", wr_en_1, 0);
        chk("off_rst_busy", busy_1, 0);
        chk("off_rst_addr", wr_addr_1, 0);
        tick(2);
        rst_1 = 1'b0;
        tick(1);
        chk("off_after_rst_en", wr_en_1, 0);
        start_1 = 1'b1; tick(1); start_1 = 1'b0;
        for (int c = 0; c < N; c++) ofm[c] = 16'(5000 + c);
        ofm_valid_1 = 1'b1; tick(1); ofm_valid_1 = 1'b0;
        chk("off_restart_addr", wr_addr_1, 256);
        chk("off_restart_data", wr_data_1, 5000);
        tick(1);
        chk("off_restart_addr2", wr_addr_1, 257);
        chk("off_overflow", overflow_1, 0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
